imm_extend_stage: RTL and testbench
===================================

# imm_extend_stage

Parametrised, pipelined immediate-extension stage for the CPU decode path. It accepts an IN_W-bit immediate and a 2-bit extension mode over a valid/ready handshake, and produces a registered OUT_W-bit result. Supported modes are sign-extend, zero-extend, upper-load (LUI) placement and branch-offset (sign-extend then shift left by 2). A 2-entry skid buffer lets the stage absorb downstream back-pressure without a combinational ready path.

## Interface
Parameters:
- IN_W, 16, immediate width; must be ≥ 2.
- OUT_W, 32, result width; must be ≥ IN_W (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds in_imm/in_mode valid.
- in_ready  output  1  stage can accept this cycle; registered.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  OUT_W  extended result; registered.
- out_mode  output  2  mode that produced out_data; registered.

## Operation
- Extension, combinational on the input side, with E = OUT_W − IN_W:
  - SIGN: {E copies of in_imm[IN_W-1], in_imm}.
  - ZERO: {E zeros, in_imm}.
  - UPPER: in_imm placed in the top IN_W bits, low E bits zero. When E = 0 the result is in_imm.
  - BRANCH: SIGN result shifted left 2, truncated to OUT_W (top 2 bits of the SIGN result dropped).
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Storage is two slots: a main register (drives the outputs) and a skid register. States:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - TWO: main full, skid full.
- Transitions:
  - EMPTY + accept → ONE (result into main).
  - ONE + accept + drain → ONE (new result into main).
  - ONE + accept, no drain → TWO (result into skid).
  - ONE + drain, no accept → EMPTY.
  - TWO + drain → ONE (skid moves to main). No accept can occur in TWO.
- in_ready = 1 in EMPTY and ONE, 0 in TWO. It is derived only from state registers; there is no path from out_ready.
- Data written to a slot is never modified until that slot is consumed.
- Order is strictly preserved (FIFO).
- in_imm and in_mode are ignored when no input transfer occurs. X on them is permitted while in_valid = 0.

## Timing
- Reset, asynchronous and immediate on assertion:
  - out_valid = 0, out_data = 0, out_mode = 0.
  - Skid cleared; state EMPTY.
  - in_ready = 1 during and after reset.
- Reset mid-operation discards both slots; no partial output follows deassertion.
- Latency: an input accepted at edge N is visible on out_data/out_valid after edge N, i.e. in cycle N+1, when the stage was EMPTY or draining.
- Throughput: 1 transfer/cycle sustained while out_ready = 1.
- After out_ready deasserts:
  - Up to 2 results are held.
  - in_ready drops the cycle after the second accept.
  - in_ready rises the cycle after the first drain from TWO.
- Simultaneous accept and drain in ONE: the outgoing item leaves, the incoming item lands in main, and out_valid stays 1.
- out_valid must not drop while out_ready = 0, and out_data/out_mode must stay stable while out_valid && !out_ready.

## Structure
- Shared package cpu_pkg:
  - mode constants EXT_SIGN = 2'b00, EXT_ZERO = 2'b01, EXT_UPPER = 2'b10, EXT_BRANCH = 2'b11;
  - the 2-bit mode type;
  - state encodings EMPTY, ONE, TWO.
- One natural sub-module: imm_extend_core, purely combinational, which maps (imm, mode) to an OUT_W result. It is reused by the decoder's bypass path.
- The skid/FSM logic stays in imm_extend_stage.

## Test plan
All scenarios use IN_W = 16, OUT_W = 32.
1. Reset: assert reset mid-stream with 2 items held → out_valid = 0, out_data = 0, in_ready = 1 immediately; nothing emitted after release.
2. Modes, with out_ready = 1 and in_imm = 16'h8004 sent in each mode:
   - SIGN → 32'hFFFF8004.
   - ZERO → 32'h00008004.
   - UPPER → 32'h80040000.
   - BRANCH → 32'hFFFE0010.
   - Each appears one cycle after acceptance.
3. Positive values: in_imm = 16'h7FFF with SIGN → 32'h00007FFF; with BRANCH → 32'h0001FFFC.
4. Back-pressure:
   - Hold out_ready = 0 and stream A, B, C.
   - A and B are accepted; in_ready = 0 from the cycle after B is accepted, so C waits.
   - Raise out_ready: order A, B, C out; out_data stable while stalled.
5. Full throughput: 100 back-to-back random items with out_ready = 1 → 100 outputs in 100 consecutive cycles, matching a reference model, and in_ready never drops.
6. Random out_ready (50%) with random in_valid for 10k cycles:
   - Scoreboard shows no loss, duplication or reordering.
   - in_ready = 0 only in TWO.
   - out_data/out_mode are stable while out_valid && !out_ready.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU decode-path definitions: immediate extension modes and the
// occupancy encoding used by the pipelined immediate-extension stage.
`timescale 1ns/1ps
package cpu_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN   = 2'b00;
  localparam ext_mode_t EXT_ZERO   = 2'b01;
  localparam ext_mode_t EXT_UPPER  = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

  // Occupancy of the main/skid register pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: maps (imm, mode) to an OUT_W-bit result.
// Shared by the registered extend stage and the decoder bypass path.
`timescale 1ns/1ps
module imm_extend_core
  import cpu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] result
);

  localparam int E = OUT_W - IN_W;

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_core: IN_W must be >= 2");
  end
  if (OUT_W < IN_W) begin : g_bad_out_w
    $error("imm_extend_core: OUT_W must be >= IN_W");
  end

  logic [OUT_W-1:0] sign_res;
  logic [OUT_W-1:0] zero_res;
  logic [OUT_W-1:0] upper_res;

  // Size casts widen only, so the signed cast replicates the top bit.
  assign sign_res = OUT_W'($signed(imm));
  assign zero_res = OUT_W'(imm);

  if (E == 0) begin : g_upper_flush
    assign upper_res = imm;
  end else begin : g_upper_pad
    assign upper_res = {imm, {E{1'b0}}};
  end

  always_comb begin
    result = sign_res;
    case (mode)
      EXT_SIGN:   result = sign_res;
      EXT_ZERO:   result = zero_res;
      EXT_UPPER:  result = upper_res;
      EXT_BRANCH: result = sign_res << 2;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer; in_ready
// is decoded from the occupancy register only, never from out_ready.
`timescale 1ns/1ps
module imm_extend_stage
  import cpu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  ext_mode_t        in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output ext_mode_t        out_mode
);

  stage_state_t     state_reg, state_next;
  logic [OUT_W-1:0] main_data_reg, skid_data_reg;
  ext_mode_t        main_mode_reg, skid_mode_reg;
  logic [OUT_W-1:0] ext_result;

  logic accept, drain;
  logic load_main, load_skid, main_from_skid;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm    (in_imm),
    .mode   (in_mode),
    .result (ext_result)
  );

  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_data_reg;
  assign out_mode  = main_mode_reg;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can move the state.
        if (drain) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_mode_reg <= EXT_SIGN;
      skid_data_reg <= '0;
      skid_mode_reg <= EXT_SIGN;
    end else begin
      state_reg <= state_next;
      if (load_main) begin
        main_data_reg <= main_from_skid ? skid_data_reg : ext_result;
        main_mode_reg <= main_from_skid ? skid_mode_reg : in_mode;
      end
      if (load_skid) begin
        skid_data_reg <= ext_result;
        skid_mode_reg <= in_mode;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage (IN_W=16, OUT_W=32): a negedge
// monitor scores every output against a queue filled at each input transfer.
`timescale 1ns/1ps
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  m;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  int          occ = 0;
  int          drains = 0;
  logic        hold = 1'b0;
  logic [31:0] held_data;
  logic [1:0]  held_mode;

  imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      passed++;
  endtask

  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {{16{imm[15]}}, imm};
      2'b01:   return {16'h0000, imm};
      2'b10:   return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  // Scoreboard and occupancy model; inputs/outputs are stable at the negedge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      sb.delete();
      occ = 0;
      hold = 1'b0;
    end else begin
      check("in_ready", {31'b0, in_ready}, {31'b0, occ < 2});
      check("out_valid", {31'b0, out_valid}, {31'b0, occ > 0});
      if (hold) begin
        check("stall_data", out_data, held_data);
        check("stall_mode", {30'b0, out_mode}, {30'b0, held_mode});
      end
      if (out_valid && out_ready) begin
        drains++;
        if (sb.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_mode", {30'b0, out_mode}, {30'b0, e.m});
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{d: model(in_imm, in_mode), m: in_mode});
      occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      hold = out_valid && !out_ready;
      held_data = out_data;
      held_mode = out_mode;
    end
  end

  // Entered and left at posedge+1; holds in_valid until accepted or timed out.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int start;
    #1;
    check("rst_in_ready_t0", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid_t0", {31'b0, out_valid}, 32'd0);
    idle(2);
    reset = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Modes, each visible the cycle after acceptance.
    send(16'h8004, 2'b00); check("sign",   out_data, 32'hFFFF8004);
    send(16'h8004, 2'b01); check("zero",   out_data, 32'h00008004);
    send(16'h8004, 2'b10); check("upper",  out_data, 32'h80040000);
    send(16'h8004, 2'b11); check("branch", out_data, 32'hFFFE0010);
    send(16'h7FFF, 2'b00); check("pos_sign",   out_data, 32'h00007FFF);
    send(16'h7FFF, 2'b11); check("pos_branch", out_data, 32'h0001FFFC);
    check("mode_tag", {30'b0, out_mode}, 32'd3);
    idle(3);

    // Back-pressure: A and B held, C waits until downstream drains.
    out_ready = 1'b0;
    send(16'h1111, 2'b01);
    send(16'h2222, 2'b00);
    check("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_head_a", out_data, 32'h00001111);
    in_valid = 1'b1; in_imm = 16'h3333; in_mode = 2'b10;
    repeat (3) begin
      idle(1);
      check("bp_c_waits", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    send(16'h3333, 2'b10);
    idle(4);
    check("bp_drained", sb.size(), 32'd0);

    // Full throughput: 100 back-to-back items.
    start = drains;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'($urandom);
      in_mode  = 2'($urandom);
      check("tp_in_ready", {31'b0, in_ready}, 32'd1);
      idle(1);
    end
    in_valid = 1'b0;
    idle(1);
    check("tp_count", 32'(drains - start), 32'd100);
    idle(2);

    // Reset mid-stream with two items held.
    out_ready = 1'b0;
    send(16'hAAAA, 2'b00);
    send(16'hBBBB, 2'b01);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("midrst_no_output", {31'b0, out_valid}, 32'd0);

    // Random traffic and back-pressure.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      idle(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(1);
    check("rand_drained", sb.size(), 32'd0);
    check("rand_idle", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
